seq_pingpong_buffer: RTL and testbench
======================================

# seq_pingpong_buffer

Parametrised successor to the single-bank sequence buffer that feeds matrix calculation and traceback. It holds NUM_BANKS independent query/database sequence pairs, loaded through a valid/ready beat stream. The next pair can load while the controller still computes and traces back on the current pair, hiding load latency between alignments. It sits between the design inputs and the controller/matrix_calculation/traceback read ports.

## Interface
Parameters:
- LETTER_WIDTH, 2: bits per letter.
- SEQ_LENGTH, 32: letters per sequence; must be a multiple of LETTERS_PER_BEAT.
- LETTERS_PER_BEAT, 4: letters accepted per channel per beat; INPUT_WIDTH = LETTERS_PER_BEAT*LETTER_WIDTH.
- NUM_BANKS, 2: sequence-pair slots, 1 to 8; a value of 1 degenerates to a single buffer.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all bank state; has the same effect as rst on control state.
- in_valid  in  1  beat present on query_in/database_in.
- in_ready  out  1  buffer can accept a beat.
- query_in  in  INPUT_WIDTH  query letters; letter k occupies bits [k*LETTER_WIDTH +: LETTER_WIDTH].
- database_in  in  INPUT_WIDTH  database letters, same packing as query_in.
- out_valid  out  1  the read bank holds a complete pair.
- query_seq_out  out  SEQ_LENGTH*LETTER_WIDTH  query letters of the read bank; index 0 is the first letter received.
- database_seq_out  out  SEQ_LENGTH*LETTER_WIDTH  database letters of the read bank.
- consume_done  in  1  controller pulse indicating the read bank is finished (traceback complete).
- occupancy  out  $clog2(NUM_BANKS+1)  number of full banks.
- underflow_err  out  1  sticky; set when consume_done arrives while out_valid=0.

## Operation
- Internal state: wr_ptr, rd_ptr (each modulo NUM_BANKS), beat_cnt (0..BEATS_PER_SEQ-1, where BEATS_PER_SEQ = SEQ_LENGTH/LETTERS_PER_BEAT), and occupancy.
- Accept: a beat is accepted when in_valid & in_ready. Beat b writes letters b*LETTERS_PER_BEAT through b*LETTERS_PER_BEAT+LETTERS_PER_BEAT-1 of bank wr_ptr, for both channels.
- in_ready = (occupancy != NUM_BANKS). This is combinational from registered state. A partially filled bank never blocks acceptance.
- Last beat (beat_cnt == BEATS_PER_SEQ-1) accepted:
  - beat_cnt returns to 0;
  - wr_ptr advances, wrapping from NUM_BANKS-1 to 0;
  - occupancy increments.
- out_valid = (occupancy != 0).
- consume_done while out_valid=1: rd_ptr advances with wrap; occupancy decrements.
- Last beat and consume_done in the same cycle: occupancy is unchanged and both pointers advance. With occupancy == NUM_BANKS, in_ready=0, so no beat can complete in that cycle.
- consume_done while out_valid=0: ignored for pointers and occupancy; underflow_err is set.
- Output sequences: a mux of bank rd_ptr, forced to all-zero when out_valid=0.
  - They are stable while out_valid=1 and consume_done=0.
  - Beats loading into other banks never disturb them.
- rst or flush:
  - clears wr_ptr, rd_ptr, beat_cnt and occupancy;
  - a partial fill is discarded;
  - rst also clears underflow_err, while flush leaves it untouched.
  - flush takes priority over a simultaneous accepted beat or consume_done; both are dropped.
- Bank storage is not reset. It is never observable because outputs are masked when out_valid=0.

## Timing
- Reset values: in_ready=1, out_valid=0, occupancy=0, underflow_err=0, query_seq_out=0, database_seq_out=0.
- Load latency: if the last beat is accepted at edge N, out_valid=1 and valid data are present after edge N.
- Sustained throughput is one beat per cycle with no bubble between banks. A full pair takes BEATS_PER_SEQ cycles.
- consume_done at edge M: the next bank's data, or out_valid=0, appears after edge M.
- Reset mid-fill or mid-consume takes effect at the next edge. in_ready is 1 in the following cycle.

## Structure
- design_variables package:
  - LETTER_WIDTH, SEQ_LENGTH and INPUT_WIDTH live here and are shared with matrix_calculation and traceback;
  - add a seq_t typedef (logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]).
- BEATS_PER_SEQ, BEAT_CNT_W and BANK_W are localparams inside the block.
- One sub-module, seq_bank: the storage for one query/database pair.
  - Inputs: wr_en and beat index.
  - Output: the two stored sequences.
  - It is instantiated NUM_BANKS times with a generate loop.

## Test plan
- Single load (defaults): after reset, send 8 beats where query_in=8'hE4 on every beat.
  - out_valid rises after the 8th beat.
  - query_seq_out letters are 0,1,2,3 repeating.
  - occupancy=1.
- Back-to-back loads: stream 24 beats (3 pairs) with in_valid held high and no consume_done.
  - in_ready drops after beat 16 with occupancy=2.
  - After consume_done, in_ready=1 and beats 17-24 fill the freed bank.
  - Pairs read out in load order.
- Simultaneous events: hold occupancy=1 and assert consume_done on the same cycle the last beat of the next pair is accepted.
  - occupancy stays 1.
  - Outputs switch to the new pair.
- Underflow: assert consume_done after reset.
  - underflow_err=1 and stays 1 until rst.
  - occupancy stays 0; flush does not clear the flag.
- Flush and reset mid-fill: assert flush after 3 beats, together with an in_valid beat.
  - The beat is dropped, occupancy=0 and beat_cnt=0.
  - A fresh 8-beat load yields exactly the new data.
  - Repeat using rst.
- Parameter sweep: NUM_BANKS=1, then NUM_BANKS=4 with LETTERS_PER_BEAT=8.
  - Pointer wrap is correct and in_ready is low exactly when all banks are full.

Source files
------------

// File: rtl/design_variables.sv
// Shared sequence geometry for the buffer, matrix_calculation and traceback.
package design_variables;

    localparam int LETTER_WIDTH     = 2;
    localparam int SEQ_LENGTH       = 32;
    localparam int LETTERS_PER_BEAT = 4;
    localparam int INPUT_WIDTH      = LETTERS_PER_BEAT * LETTER_WIDTH;

    typedef logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] seq_t;

    // Counter/pointer width that stays at least one bit for a single-entry range.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_bank.sv
// One query/database pair store, written one beat at a time; no reset on the data.
// Write lands on the edge wr_en_i is sampled high; no backpressure of its own.
module seq_bank #(
    parameter int LETTER_WIDTH     = 2,
    parameter int SEQ_LENGTH       = 32,
    parameter int LETTERS_PER_BEAT = 4,
    parameter int BEATS_PER_SEQ    = 8,
    parameter int BEAT_CNT_W       = 3
) (
    input  logic                                      clk,
    input  logic                                      wr_en_i,
    input  logic [BEAT_CNT_W-1:0]                     beat_idx_i,
    input  logic [LETTERS_PER_BEAT*LETTER_WIDTH-1:0]  query_i,
    input  logic [LETTERS_PER_BEAT*LETTER_WIDTH-1:0]  database_i,
    output logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]   query_seq_o,
    output logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]   database_seq_o
);

    localparam int IW = LETTERS_PER_BEAT * LETTER_WIDTH;

    // Beat-major layout is bit-identical to the letter-major output view.
    logic [BEATS_PER_SEQ-1:0][IW-1:0] query_q;
    logic [BEATS_PER_SEQ-1:0][IW-1:0] database_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            query_q[beat_idx_i]    <= query_i;
            database_q[beat_idx_i] <= database_i;
        end
    end

    assign query_seq_o    = query_q;
    assign database_seq_o = database_q;

endmodule

// File: rtl/seq_pingpong_buffer.sv
// NUM_BANKS-deep ring of sequence pairs so the next pair loads while the current one is consumed.
// Pair visible the cycle after its last beat; in_ready drops only when every bank is full.
module seq_pingpong_buffer
    import design_variables::*;
#(
    parameter int LETTER_WIDTH     = design_variables::LETTER_WIDTH,
    parameter int SEQ_LENGTH       = design_variables::SEQ_LENGTH,
    parameter int LETTERS_PER_BEAT = design_variables::LETTERS_PER_BEAT,
    parameter int NUM_BANKS        = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [LETTERS_PER_BEAT*LETTER_WIDTH-1:0]  query_in,
    input  logic [LETTERS_PER_BEAT*LETTER_WIDTH-1:0]  database_in,
    output logic                                      out_valid,
    output logic [SEQ_LENGTH*LETTER_WIDTH-1:0]        query_seq_out,
    output logic [SEQ_LENGTH*LETTER_WIDTH-1:0]        database_seq_out,
    input  logic                                      consume_done,
    output logic [$clog2(NUM_BANKS+1)-1:0]            occupancy,
    output logic                                      underflow_err
);

    localparam int BEATS_PER_SEQ = SEQ_LENGTH / LETTERS_PER_BEAT;
    localparam int BEAT_CNT_W    = cnt_w(BEATS_PER_SEQ);
    localparam int BANK_W        = cnt_w(NUM_BANKS);
    localparam int OCC_W         = $clog2(NUM_BANKS + 1);
    localparam int SEQ_W         = SEQ_LENGTH * LETTER_WIDTH;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_SEQ - 1);
    localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [OCC_W-1:0]      FULL_OCC  = OCC_W'(NUM_BANKS);

    logic [BANK_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  underflow_q, underflow_d;

    logic accept, last_beat, consume;
    logic [SEQ_W-1:0] bank_query    [NUM_BANKS];
    logic [SEQ_W-1:0] bank_database [NUM_BANKS];

    assign in_ready      = (occ_q != FULL_OCC);
    assign out_valid     = (occ_q != '0);
    assign occupancy     = occ_q;
    assign underflow_err = underflow_q;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt_q == LAST_BEAT);
    assign consume   = consume_done && out_valid;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        occ_d       = occ_q;
        underflow_d = underflow_q;
        if (flush) begin
            // Drops any beat or consume in the same cycle; the error flag survives.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            beat_cnt_d = '0;
            occ_d      = '0;
        end else begin
            if (accept) begin
                beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
            end
            if (last_beat) begin
                wr_ptr_d = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + 1'b1;
            end
            if (consume) begin
                rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + 1'b1;
            end
            if (last_beat && !consume) begin
                occ_d = occ_q + 1'b1;
            end else if (consume && !last_beat) begin
                occ_d = occ_q - 1'b1;
            end
            if (consume_done && !out_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            occ_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            occ_q       <= occ_d;
            underflow_q <= underflow_d;
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        seq_bank #(
            .LETTER_WIDTH    (LETTER_WIDTH),
            .SEQ_LENGTH      (SEQ_LENGTH),
            .LETTERS_PER_BEAT(LETTERS_PER_BEAT),
            .BEATS_PER_SEQ   (BEATS_PER_SEQ),
            .BEAT_CNT_W      (BEAT_CNT_W)
        ) u_bank (
            .clk           (clk),
            .wr_en_i       (accept && !flush && !rst && (wr_ptr_q == BANK_W'(i))),
            .beat_idx_i    (beat_cnt_q),
            .query_i       (query_in),
            .database_i    (database_in),
            .query_seq_o   (bank_query[i]),
            .database_seq_o(bank_database[i])
        );
    end

    // Bank contents are never reset, so the mask is what keeps stale data invisible.
    assign query_seq_out    = out_valid ? bank_query[rd_ptr_q]    : '0;
    assign database_seq_out = out_valid ? bank_database[rd_ptr_q] : '0;

endmodule

// File: tb/tb_seq_pingpong_buffer.sv
// Bench for seq_pingpong_buffer in three configurations, each against a queue-based pair model.
module tb_seq_pingpong_buffer;

    int checks   = 0;
    int failures = 0;
    logic clk = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d got=%0h want=%0h", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int NB    = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
        localparam int LPB   = (g == 2) ? 8 : 4;
        localparam int IW    = LPB * 2;
        localparam int BEATS = 32 / LPB;
        localparam int OW    = $clog2(NB + 1);
        localparam logic [IW-1:0] PAT_E4 = {(LPB/4){8'hE4}};
        localparam logic [IW-1:0] PAT_1B = {(LPB/4){8'h1B}};
        localparam logic [IW-1:0] PAT_4E = {(LPB/4){8'h4E}};

        logic rst, flush, in_valid, in_ready, consume_done, out_valid, underflow_err;
        logic [IW-1:0] query_in, database_in;
        logic [63:0]   qs, ds;
        logic [OW-1:0] occupancy;
        bit fin = 1'b0;

        seq_pingpong_buffer #(
            .LETTER_WIDTH(2), .SEQ_LENGTH(32), .LETTERS_PER_BEAT(LPB), .NUM_BANKS(NB)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
            .query_in(query_in), .database_in(database_in), .out_valid(out_valid),
            .query_seq_out(qs), .database_seq_out(ds), .consume_done(consume_done),
            .occupancy(occupancy), .underflow_err(underflow_err)
        );

        // Model: FIFO of complete pairs plus one pair being assembled.
        logic [63:0] mq[$];
        logic [63:0] md[$];
        logic [63:0] pq, pd;
        int pcnt = 0;
        bit uf = 1'b0;
        bit live = 1'b0;

        always @(posedge clk) begin
            bit rdy;
            if (rst) begin
                mq.delete(); md.delete(); pcnt = 0; uf = 1'b0; live = 1'b1;
            end else if (live) begin
                if (flush) begin
                    mq.delete(); md.delete(); pcnt = 0;
                end else begin
                    rdy = (mq.size() != NB);
                    if (consume_done) begin
                        if (mq.size() != 0) begin
                            void'(mq.pop_front());
                            void'(md.pop_front());
                        end else begin
                            uf = 1'b1;
                        end
                    end
                    if (in_valid && rdy) begin
                        pq[pcnt*IW +: IW] = query_in;
                        pd[pcnt*IW +: IW] = database_in;
                        pcnt++;
                        if (pcnt == BEATS) begin
                            mq.push_back(pq);
                            md.push_back(pd);
                            pcnt = 0;
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (live) begin
                chk("in_ready", g, 64'(in_ready), 64'(mq.size() != NB));
                chk("out_valid", g, 64'(out_valid), 64'(mq.size() != 0));
                chk("occupancy", g, 64'(occupancy), 64'(mq.size()));
                chk("underflow_err", g, 64'(underflow_err), 64'(uf));
                chk("query_seq_out", g, qs, (mq.size() != 0) ? mq[0] : 64'd0);
                chk("database_seq_out", g, ds, (md.size() != 0) ? md[0] : 64'd0);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic reset_pulse();
            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; consume_done = 1'b0;
            tick();
            rst = 1'b0;
        endtask

        task automatic load(input logic [IW-1:0] q, input int n);
            in_valid = 1'b1;
            for (int b = 0; b < n; b++) begin
                query_in = q;
                database_in = IW'($urandom);
                tick();
            end
            in_valid = 1'b0;
        endtask

        initial begin
            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; consume_done = 1'b0;
            query_in = '0; database_in = '0;
            tick();
            rst = 1'b0;
            chk("rst_in_ready", g, 64'(in_ready), 64'd1);
            chk("rst_out_valid", g, 64'(out_valid), 64'd0);
            chk("rst_occupancy", g, 64'(occupancy), 64'd0);
            chk("rst_underflow", g, 64'(underflow_err), 64'd0);
            chk("rst_query", g, qs, 64'd0);
            chk("rst_database", g, ds, 64'd0);

            // Single load of a repeating 0,1,2,3 letter pattern.
            load(PAT_E4, BEATS - 1);
            chk("single_not_yet", g, 64'(out_valid), 64'd0);
            load(PAT_E4, 1);
            chk("single_valid", g, 64'(out_valid), 64'd1);
            chk("single_query", g, qs, 64'hE4E4_E4E4_E4E4_E4E4);
            chk("single_occ", g, 64'(occupancy), 64'd1);

            // Back-to-back until every bank is full, then free one and keep streaming.
            reset_pulse();
            in_valid = 1'b1;
            for (int b = 0; b < NB * BEATS + 2; b++) begin
                query_in = IW'($urandom); database_in = IW'($urandom);
                tick();
            end
            chk("b2b_full_ready", g, 64'(in_ready), 64'd0);
            chk("b2b_full_occ", g, 64'(occupancy), 64'(NB));
            consume_done = 1'b1;
            tick();
            consume_done = 1'b0;
            chk("b2b_freed_ready", g, 64'(in_ready), 64'd1);
            for (int b = 0; b < BEATS; b++) begin
                query_in = IW'($urandom); database_in = IW'($urandom);
                tick();
            end
            in_valid = 1'b0;
            chk("b2b_refill_occ", g, 64'(occupancy), 64'(NB));
            consume_done = 1'b1;
            for (int b = 0; b < NB; b++) tick();
            consume_done = 1'b0;
            chk("b2b_drained_occ", g, 64'(occupancy), 64'd0);

            // Last beat of the next pair coincides with consume of the current one.
            reset_pulse();
            load('0, BEATS);
            load('1, BEATS - 1);
            in_valid = 1'b1; query_in = '1; consume_done = 1'b1;
            tick();
            in_valid = 1'b0; consume_done = 1'b0;
            chk("simul_occ", g, 64'(occupancy), (NB > 1) ? 64'd1 : 64'd0);
            chk("simul_query", g, qs, (NB > 1) ? {64{1'b1}} : 64'd0);

            // Underflow is sticky through flush, cleared by rst.
            reset_pulse();
            consume_done = 1'b1;
            tick();
            consume_done = 1'b0;
            chk("uf_set", g, 64'(underflow_err), 64'd1);
            chk("uf_occ", g, 64'(occupancy), 64'd0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("uf_after_flush", g, 64'(underflow_err), 64'd1);
            reset_pulse();
            chk("uf_after_rst", g, 64'(underflow_err), 64'd0);

            // Flush mid-fill together with a beat, then a clean load.
            load(IW'($urandom), 3);
            in_valid = 1'b1; query_in = '1; flush = 1'b1;
            tick();
            in_valid = 1'b0; flush = 1'b0;
            chk("flush_occ", g, 64'(occupancy), 64'd0);
            load(PAT_1B, BEATS);
            chk("flush_reload_query", g, qs, 64'h1B1B_1B1B_1B1B_1B1B);
            chk("flush_reload_occ", g, 64'(occupancy), 64'd1);

            // Same again with rst.
            reset_pulse();
            load(IW'($urandom), 3);
            in_valid = 1'b1; query_in = '1; rst = 1'b1;
            tick();
            in_valid = 1'b0; rst = 1'b0;
            chk("rst_mid_occ", g, 64'(occupancy), 64'd0);
            chk("rst_mid_ready", g, 64'(in_ready), 64'd1);
            load(PAT_4E, BEATS);
            chk("rst_reload_query", g, qs, 64'h4E4E_4E4E_4E4E_4E4E);

            // Random traffic: light then heavy consumption.
            for (int c = 0; c < 3000; c++) begin
                rst          = ($urandom_range(0, 999) < 3);
                flush        = ($urandom_range(0, 999) < 8);
                in_valid     = ($urandom_range(0, 9) < 7);
                consume_done = (c < 1500) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
                query_in     = IW'($urandom);
                database_in  = IW'($urandom);
                tick();
            end
            rst = 1'b0; flush = 1'b0; in_valid = 1'b0; consume_done = 1'b0;
            tick();
            fin = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
            failures++;
            $display("FAIL timeout got=%0d want=completion", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
